// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the mantissa multiplier arbiter.
//   PROD_W  : product width for the default 24-bit mantissa
//   tag_t   : in-flight tag {valid, requester id}
//   rr_pick : round-robin one-hot pick starting after the last grant
package mul_arb_pkg;

  localparam int unsigned MaxReq    = 4;
  localparam int unsigned ID_W      = 2;
  localparam int unsigned WIDTH_DEF = 24;
  localparam int unsigned PROD_W    = 2 * WIDTH_DEF;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

  // Scan n_req slots starting at last+1; the first eligible slot wins.
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] elig,
                                                input logic [ID_W-1:0]   last,
                                                input int unsigned       n_req);
    logic [MaxReq-1:0] gnt;
    logic [ID_W-1:0]   idx;
    gnt = '0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      if (k <= n_req) begin
        idx = ID_W'((32'(last) + k) % n_req);
        if (gnt == '0 && elig[idx]) gnt[idx] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mul_rsp_fifo.sv
// Per-requester result FIFO, not fall-through: dout is the registered head entry.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write one entry (never issued when full)
//   pop        : drop the head entry (only when count != 0)
//   dout       : head entry
//   count      : occupancy, 0..DEPTH
module mul_rsp_fifo #(
  parameter int unsigned DW    = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              din,
  input  logic                       pop,
  output logic [DW-1:0]              dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + PtrW'(1);
      end
      if (pop) rd_q <= rd_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/mant_mul_arbiter.sv
// Round-robin scheduler sharing one pipelined mantissa multiplier between N_REQ requesters.
//   req_valid/req_ready/req_a/req_b : per-requester operand handshake (ready = grant)
//   mul_valid/mul_a/mul_b/mul_z     : registered issue to the multiplier, product MUL_LAT later
//   rsp_valid/rsp_ready/rsp_z       : per-requester result FIFO head
//   busy                            : any op in flight or any result buffered
module mant_mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned MUL_LAT    = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  output logic                       mul_valid,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic [2*WIDTH-1:0]         mul_z,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [N_REQ*2*WIDTH-1:0]   rsp_z,
  output logic                       busy
);

  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  // cred = in-flight ops plus FIFO occupancy; capping it at FIFO_DEPTH makes overflow impossible.
  logic [CntW-1:0]   cred_q [N_REQ];
  logic [CntW-1:0]   cred_d [N_REQ];
  logic [ID_W-1:0]   last_q;
  logic [N_REQ-1:0]  elig, grant, push, pop;
  logic [MaxReq-1:0] elig_ext, pick_ext;
  logic [ID_W-1:0]   grant_id;
  logic              any_grant, any_cred;
  logic              mul_valid_q, busy_q;
  logic [WIDTH-1:0]  mul_a_q, mul_b_q;

  // Stage 0 is loaded alongside mul_valid; stage MUL_LAT lines up with mul_z.
  tag_t tag_q [MUL_LAT+1];

  always_comb begin
    elig_ext = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      elig[i]     = req_valid[i] && (cred_q[i] < CntW'(FIFO_DEPTH));
      elig_ext[i] = elig[i];
    end
    pick_ext = rr_pick(elig_ext, last_q, N_REQ);
    // Held low while reset is asserted so no handshake completes during reset.
    grant     = pick_ext[N_REQ-1:0] & {N_REQ{rst_n}};
    any_grant = |grant;
    grant_id  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_id = ID_W'(i);
    end
  end

  assign req_ready = grant;

  always_comb begin
    any_cred = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      push[i]   = tag_q[MUL_LAT].v && (tag_q[MUL_LAT].id == ID_W'(i));
      pop[i]    = rsp_valid[i] && rsp_ready[i];
      cred_d[i] = cred_q[i] + CntW'(grant[i]) - CntW'(pop[i]);
      any_cred  = any_cred | (cred_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) cred_q[i] <= '0;
      for (int s = 0; s <= MUL_LAT; s++) tag_q[s] <= '0;
      last_q      <= ID_W'(N_REQ - 1);
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) cred_q[i] <= cred_d[i];
      tag_q[0] <= '{v: any_grant, id: grant_id};
      for (int s = 1; s <= MUL_LAT; s++) tag_q[s] <= tag_q[s-1];
      mul_valid_q <= any_grant;
      if (any_grant) begin
        last_q  <= grant_id;
        mul_a_q <= req_a[grant_id*WIDTH +: WIDTH];
        mul_b_q <= req_b[grant_id*WIDTH +: WIDTH];
      end
      busy_q <= any_cred;
    end
  end

  assign mul_valid = mul_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = busy_q;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    logic [CntW-1:0]  fifo_count;
    logic [ProdW-1:0] fifo_dout;

    mul_rsp_fifo #(
      .DW    (ProdW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .din   (mul_z),
      .pop   (pop[i]),
      .dout  (fifo_dout),
      .count (fifo_count)
    );

    assign rsp_valid[i]               = (fifo_count != '0);
    assign rsp_z[i*ProdW +: ProdW]    = fifo_dout;
  end

endmodule

// File: tb/tb_mant_mul_arbiter.sv
module tb_mant_mul_arbiter;

  localparam int N       = 2;
  localparam int W       = 24;
  localparam int LAT     = 3;
  localparam int DEPTH   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic             mul_valid;
  logic [W-1:0]     mul_a, mul_b;
  logic [2*W-1:0]   mul_z;
  logic [N-1:0]     rsp_valid, rsp_ready;
  logic [N*2*W-1:0] rsp_z;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  // Multiplier model: fixed latency, never stalls; optional noise on mul_z.
  logic [2*W-1:0] pipe [LAT];
  logic           noise_en = 1'b0;
  logic           tog = 1'b0;

  always @(posedge clk) begin
    pipe[0] <= 48'(mul_a) * 48'(mul_b);
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    tog <= ~tog;
  end
  assign mul_z = pipe[LAT-1] ^ (noise_en ? (48'hA5A5A55A5A5A ^ {48{tog}}) : 48'h0);

  always #5 clk = ~clk;

  mant_mul_arbiter #(
    .N_REQ      (N),
    .WIDTH      (W),
    .MUL_LAT    (LAT),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_valid (mul_valid),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_z     (mul_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .busy      (busy)
  );

  // FIFO overflow must never occur.
  always @(negedge clk) begin
    if (rst_n) begin
      if (u_dut.g_req[0].u_fifo.push && u_dut.g_req[0].u_fifo.count == 3'(DEPTH)) begin
        n_fail++;
        $display("FAIL overflow0: push while count=%0d, required count<%0d",
                 u_dut.g_req[0].u_fifo.count, DEPTH);
      end
      if (u_dut.g_req[1].u_fifo.push && u_dut.g_req[1].u_fifo.count == 3'(DEPTH)) begin
        n_fail++;
        $display("FAIL overflow1: push while count=%0d, required count<%0d",
                 u_dut.g_req[1].u_fifo.count, DEPTH);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;
    #2;
    n_chk += 7;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
    if (mul_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mul_valid: got %b want 0", mul_valid); end
    if (mul_a !== 24'h0) begin n_fail++; $display("FAIL rst_mul_a: got %h want 0", mul_a); end
    if (mul_b !== 24'h0) begin n_fail++; $display("FAIL rst_mul_b: got %h want 0", mul_b); end
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
    if (rsp_z !== 96'h0) begin n_fail++; $display("FAIL rst_rsp_z: got %h want 0", rsp_z); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [47:0] exp_z;
    exp_z     = 48'h400000000000;
    rsp_ready = 2'b11;
    req_a     = {24'h0, 24'h800000};
    req_b     = {24'h0, 24'h800000};
    req_valid = 2'b01;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b want 01", req_ready); end
    step();
    req_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_chk += 2;
        if (mul_valid !== 1'b1) begin n_fail++; $display("FAIL single_mul_valid: got %b want 1", mul_valid); end
        if (mul_a !== 24'h800000) begin n_fail++; $display("FAIL single_mul_a: got %h want 800000", mul_a); end
      end
      n_chk += 2;
      if (rsp_valid[0] !== (k == 5)) begin
        n_fail++; $display("FAIL single_rsp_valid c%0d: got %b want %b", k, rsp_valid[0], (k == 5));
      end
      if (busy !== (k <= 5)) begin
        n_fail++; $display("FAIL single_busy c%0d: got %b want %b", k, busy, (k <= 5));
      end
      if (k == 5) begin
        n_chk++;
        if (rsp_z[47:0] !== exp_z) begin n_fail++; $display("FAIL single_z: got %h want %h", rsp_z[47:0], exp_z); end
      end
      step();
    end
  endtask

  task automatic test_max();
    req_a     = {24'h0, 24'hFFFFFF};
    req_b     = {24'h0, 24'hFFFFFF};
    req_valid = 2'b01;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL max_grant0: got %b want 01", req_ready); end
    step();
    req_a = {24'h0, 24'h000000};
    @(negedge clk);
    n_chk++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL max_grant1: got %b want 01", req_ready); end
    step();
    req_valid = '0;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      n_chk++;
      if (rsp_valid[0] !== (k == 5 || k == 6)) begin
        n_fail++; $display("FAIL max_rsp_valid c%0d: got %b want %b", k, rsp_valid[0], (k == 5 || k == 6));
      end
      if (k == 5) begin
        n_chk++;
        if (rsp_z[47:0] !== 48'hFFFFFE000001) begin
          n_fail++; $display("FAIL max_z_ff: got %h want fffffe000001", rsp_z[47:0]);
        end
      end
      if (k == 6) begin
        n_chk++;
        if (rsp_z[47:0] !== 48'h0) begin n_fail++; $display("FAIL max_z_zero: got %h want 0", rsp_z[47:0]); end
      end
      step();
    end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_g, exp_v;
    logic [47:0] exp_z;
    do_reset();
    req_a     = {24'h000007, 24'h000003};
    req_b     = {24'h000009, 24'h000005};
    req_valid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_chk++;
      if (req_ready !== exp_g) begin n_fail++; $display("FAIL fair_grant c%0d: got %b want %b", k, req_ready, exp_g); end
      if (k >= 5) begin
        exp_v = ((k - 5) % 2 == 0) ? 2'b01 : 2'b10;
        n_chk += 2;
        if (rsp_valid !== exp_v) begin
          n_fail++; $display("FAIL fair_rsp_valid c%0d: got %b want %b", k, rsp_valid, exp_v);
        end
        exp_z = (exp_v == 2'b01) ? 48'h00000000000F : 48'h00000000003F;
        if (((exp_v == 2'b01) ? rsp_z[47:0] : rsp_z[95:48]) !== exp_z) begin
          n_fail++; $display("FAIL fair_z c%0d: got %h want %h", k, rsp_z, exp_z);
        end
      end
      step();
    end
    req_valid = '0;
    for (int k = 0; k < 8; k++) step();
  endtask

  task automatic test_backpressure();
    int n0, n1, pops, acc1;
    do_reset();
    n0 = 0; n1 = 0;
    rsp_ready = 2'b01;
    req_a     = {24'h000001, 24'h000002};
    req_b     = {24'h000010, 24'h000003};
    req_valid = 2'b11;
    for (int k = 0; k < 30; k++) begin
      req_a[47:24] = 24'(n1 + 1);
      @(negedge clk);
      if (req_ready[1]) n1++;
      if (req_ready[0] && k >= 10) n0++;
      step();
    end
    n_chk += 4;
    if (n1 != 4) begin n_fail++; $display("FAIL bp_req1_accepts: got %0d want 4", n1); end
    if (n0 < 12) begin n_fail++; $display("FAIL bp_req0_issues: got %0d want >=12", n0); end
    if (rsp_valid[1] !== 1'b1) begin n_fail++; $display("FAIL bp_held_valid: got %b want 1", rsp_valid[1]); end
    if (rsp_z[95:48] !== 48'h10) begin n_fail++; $display("FAIL bp_held_z: got %h want 10", rsp_z[95:48]); end
    rsp_ready = 2'b11;
    pops = 0; acc1 = -1;
    for (int k = 0; k < 12; k++) begin
      req_a[47:24] = 24'(n1 + 1);
      @(negedge clk);
      if (rsp_valid[1] && pops < 4) begin
        n_chk += 2;
        if (rsp_z[95:48] !== 48'((pops + 1) * 16)) begin
          n_fail++; $display("FAIL bp_pop_z%0d: got %h want %h", pops, rsp_z[95:48], 48'((pops + 1) * 16));
        end
        if (k != pops) begin n_fail++; $display("FAIL bp_pop_cycle%0d: got %0d want %0d", pops, k, pops); end
        pops++;
      end
      if (req_ready[1]) begin
        if (acc1 < 0) acc1 = k;
        n1++;
      end
      step();
    end
    n_chk += 2;
    if (pops != 4) begin n_fail++; $display("FAIL bp_pop_count: got %0d want 4", pops); end
    if (acc1 != 1) begin n_fail++; $display("FAIL bp_reaccept: got cycle %0d want 1", acc1); end
    req_valid = '0;
    for (int k = 0; k < 12; k++) step();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 2'b11;
    req_b     = {24'h0, 24'h000001};
    req_valid = 2'b01;
    for (int j = 0; j < 3; j++) begin
      req_a = {24'h0, 24'(j + 1)};
      step();
    end
    req_valid = '0;
    #2;
    rst_n     = 1'b0;
    req_valid = 2'b01;
    #1;
    n_chk += 7;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL mid_req_ready: got %b want 00", req_ready); end
    if (mul_valid !== 1'b0) begin n_fail++; $display("FAIL mid_mul_valid: got %b want 0", mul_valid); end
    if (mul_a !== 24'h0) begin n_fail++; $display("FAIL mid_mul_a: got %h want 0", mul_a); end
    if (mul_b !== 24'h0) begin n_fail++; $display("FAIL mid_mul_b: got %h want 0", mul_b); end
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_rsp_valid: got %b want 00", rsp_valid); end
    if (rsp_z !== 96'h0) begin n_fail++; $display("FAIL mid_rsp_z: got %h want 0", rsp_z); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    step();
    req_valid = '0;
    rst_n     = 1'b1;
    noise_en  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        n_fail++; $display("FAIL mid_quiet c%0d: got valid=%b busy=%b want 00/0", k, rsp_valid, busy);
      end
      step();
    end
    noise_en  = 1'b0;
    req_a     = {24'h0, 24'h123456};
    req_b     = {24'h0, 24'h000010};
    req_valid = 2'b01;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_grant: got %b want 01", req_ready); end
    step();
    req_valid = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_chk++;
      if (rsp_valid[0] !== (k == 5)) begin
        n_fail++; $display("FAIL mid_rsp_valid c%0d: got %b want %b", k, rsp_valid[0], (k == 5));
      end
      if (k == 5) begin
        n_chk++;
        if (rsp_z[47:0] !== 48'h000001234560) begin
          n_fail++; $display("FAIL mid_z: got %h want 000001234560", rsp_z[47:0]);
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_max();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
